// File: rtl/mux_lut_gate_pipe.sv
// Configurable bitwise logic unit. Each result bit is a 2:1 mux tree
// indexed by the operand bits and driven by a 4-bit truth table. There are
// seven fixed functions and one runtime-loadable custom function. It has a
// two-stage valid/ready pipeline with full throughput and backpressure.
module mux_lut_gate_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  // Truth tables indexed by {a_i, b_i}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NOTA = 4'b0011;

  logic [3:0]       cfg_q;
  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [3:0]       tt_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] y_p2;
  logic             load_p2;

  // Map the function select onto its truth table; op 7 takes the custom table.
  function automatic logic [3:0] resolve_tt(input logic [2:0] sel,
                                            input logic [3:0] custom);
    logic [3:0] t;
    case (sel)
      3'd0:    t = TT_AND;
      3'd1:    t = TT_OR;
      3'd2:    t = TT_XOR;
      3'd3:    t = TT_NAND;
      3'd4:    t = TT_NOR;
      3'd5:    t = TT_XNOR;
      3'd6:    t = TT_NOTA;
      default: t = custom;
    endcase
    return t;
  endfunction

  // Per-bit mux tree: b picks within each table half, and a picks the half.
  function automatic logic [WIDTH-1:0] eval_tt(input logic [WIDTH-1:0] xa,
                                               input logic [WIDTH-1:0] xb,
                                               input logic [3:0]       tt);
    logic [WIDTH-1:0] r;
    logic             lo;
    logic             hi;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lo   = xb[i] ? tt[1] : tt[0];
      hi   = xb[i] ? tt[3] : tt[2];
      r[i] = xa[i] ? hi : lo;
    end
    return r;
  endfunction

  // Stage 2 advances when empty or being drained. Stage 1 advances when empty or moving into stage 2.
  assign load_p2   = !vld_p2 || out_ready;
  assign in_ready  = !rst && (!vld_p1 || load_p2);
  assign out_valid = vld_p2;
  assign y         = y_p2;

  // Custom truth-table register. It loads independently of the handshakes.
  always_ff @(posedge clk) begin
    if (rst)
      cfg_q <= 4'b0000;
    else if (cfg_we)
      cfg_q <= cfg_tt;
  end

  // ---- stage 1: accept operands and snapshot the resolved truth table ----
  // Stage-1 occupancy
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (in_ready)
      vld_p1 <= in_valid;
  end

  // Stage-1 payload. The custom table is captured now, so later writes do not affect it.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1  <= a;
      b_p1  <= b;
      tt_p1 <= resolve_tt(op, cfg_q);
    end
  end

  // ---- stage 2: evaluate mux trees and present the result ----
  // Result register. y is cleared on reset, so the output shows a known value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      y_p2   <= '0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1)
        y_p2 <= eval_tt(a_p1, b_p1, tt_p1);
    end
  end

endmodule

// File: doc/mux_lut_gate_pipe.md
# mux_lut_gate_pipe

Parametrised, pipelined logic unit that evaluates any two-input bitwise function of two WIDTH-bit operands using per-bit 2:1 mux trees driven by a 4-bit truth table. It extends the mux-built AND/OR gate to eight selectable functions, including a runtime-loadable custom function. Operands enter and results leave through valid/ready handshakes. It sits in the datapath wherever a configurable bitwise operator with backpressure is needed.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  unit can accept this cycle
- a  in  WIDTH  operand A (final mux select per bit)
- b  in  WIDTH  operand B (first-level mux select per bit)
- op  in  3  function select, sampled with a/b
- cfg_we  in  1  write cfg_tt into custom truth-table register
- cfg_tt  in  4  custom truth table
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result

## Operation
- Truth table tt[3:0]: result bit = tt[{a_i,b_i}]. Each bit is evaluated as a mux tree: level 1 picks tt[0]/tt[1] and tt[2]/tt[3] by b_i, level 2 picks between them by a_i.
- op map → tt: 0 AND 4'b1000, 1 OR 4'b1110, 2 XOR 4'b0110, 3 NAND 4'b0111, 4 NOR 4'b0001, 5 XNOR 4'b1001, 6 NOT-A 4'b0011, 7 CUSTOM = cfg register.
- cfg register: reset 4'b0000; loads cfg_tt on any cycle with cfg_we=1, independent of the handshakes.
- Stage 1 (accept): on in_valid && in_ready, register a, b and the resolved tt. op 7 snapshots cfg at accept time, so later cfg writes do not affect in-flight transactions.
- Stage 2 (result): evaluate the mux trees on stage-1 contents and register them into y with out_valid.
- Flow control, per stage: a stage loads when it is empty or its content leaves in the same cycle.
  - Stage 2 loads when !out_valid || out_ready.
  - in_ready = !s1_valid || stage-2 load condition. in_ready is combinational from state and out_ready; it has no path from in_valid.
- Holding: while out_valid && !out_ready, y and out_valid hold stable and stage 1 holds. Once both stages are full, in_ready=0.

## Timing
- Reset values: s1_valid=0, out_valid=0, y=0, cfg=4'b0000. in_ready=0 while rst=1 and 1 on the first cycle after.
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+1. That is 2 cycles from in_valid presentation to out_valid when unstalled.
- Throughput: 1 transaction/cycle with out_ready held high. No bubbles are inserted.
- Simultaneous cfg_we and op 7 accept: the transaction uses the old cfg. The new value applies from the next accept.
- Simultaneous pop (out_ready) and push with both stages full: both stages advance, and no data is lost or duplicated.
- Reset mid-operation: all in-flight transactions are discarded, the outputs take their reset values on the next edge, and cfg returns to 0.
- op values are all defined (3-bit map is total).
- Arithmetic: purely bitwise. No carries, and no width growth between a/b and y.

## Test plan
- All ops, WIDTH=8, a=8'hCC, b=8'hAA, out_ready=1. Expected y: AND 8'h88, OR 8'hEE, XOR 8'h66, NAND 8'h77, NOR 8'h11, XNOR 8'h99, NOT-A 8'h33. Each appears 2 cycles after presentation, with back-to-back results on consecutive cycles.
- Custom and snapshot: cfg_we with cfg_tt=4'b0100, then op 7, a=8'hF0, b=8'h0F → y=8'hF0 (tt[2]: a=1, b=0). Write cfg_tt=4'b1000 in the same cycle as a second op 7 accept (same a/b) → that result is still 8'hF0. A third accept after the write → 8'h00 (tt[3] only; no a=1,b=1 bits).
- Backpressure: hold out_ready=0 and stream 3 transactions. in_ready drops after 2 accepts, and y stays stable. Release out_ready → results emerge in order with none lost or duplicated.
- Reset mid-stream: assert rst with both stages full → the next cycle has out_valid=0 and y=0, and after a prior cfg write cfg reads back 0 (op 7 with a=b=8'hFF gives y=8'h00).
- Parameter sweep: WIDTH=1 and WIDTH=32, random a/b/op with random out_ready → bit-exact match to a reference model, in order.
